// File: rtl/hdu_sb.sv
// hdu_sb: load-use hazard unit with a LOAD_LAT-deep load scoreboard,
// branch flush, SRAM stall priority, saturating event counters and a stall watchdog.
module hdu_sb #(
   parameter int REG_AW       = 5,
   parameter int LOAD_LAT     = 1,
   parameter int FLUSH_DEPTH  = 2,
   parameter int CNT_W        = 16,
   parameter int SRAM_TIMEOUT = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_sram_stall,
   input  logic              i_br_flush,
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_rs1_used,
   input  logic              i_id_rs2_used,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic              i_id_rdwren,
   input  logic              i_id_mem_rden,
   output logic              o_pc_wren,
   output logic              o_ifid_wren,
   output logic              o_idex_wren,
   output logic              o_exmem_wren,
   output logic              o_memwb_wren,
   output logic              o_ifid_clear,
   output logic              o_idex_clear,
   output logic              o_exmem_clear,
   output logic [CNT_W-1:0]  o_bubble_cnt,
   output logic [CNT_W-1:0]  o_flush_cnt,
   output logic              o_sram_timeout
);
   localparam int FD = (FLUSH_DEPTH < LOAD_LAT) ? FLUSH_DEPTH : LOAD_LAT;
   localparam int SW = $clog2(SRAM_TIMEOUT + 1);
   localparam logic [SW-1:0] RUN_MAX = SW'(SRAM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [LOAD_LAT-1:0] r_sb_v;
   logic [REG_AW-1:0]   r_sb_rd [LOAD_LAT];
   logic [LOAD_LAT-1:0] w_v_nxt;
   logic [REG_AW-1:0]   w_rd_nxt [LOAD_LAT];
   logic [CNT_W-1:0]    r_bubble_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;
   logic [SW-1:0]       r_stall_run;
   logic                r_timeout;
   logic                w_luh;
   logic                w_push;

   always_comb begin
      w_luh = 1'b0;
      for (int k = 0; k < LOAD_LAT; k++)
         w_luh = w_luh | (r_sb_v[k] &
                 ((i_id_rs1_used & (i_id_rs1 != '0) & (i_id_rs1 == r_sb_rd[k])) |
                  (i_id_rs2_used & (i_id_rs2 != '0) & (i_id_rs2 == r_sb_rd[k]))));
   end

   assign w_push = i_id_mem_rden & i_id_rdwren & (i_id_rd != '0) & ~w_luh & ~i_br_flush;

   // entry 0 takes the new load (or the bubble), older entries shift; flush kills the youngest FD
   for (genvar k = 0; k < LOAD_LAT; k++) begin : g_sb
      if (k == 0) begin : g_head
         assign w_v_nxt[k]  = w_push;
         assign w_rd_nxt[k] = i_id_rd;
      end else begin : g_tail
         assign w_v_nxt[k]  = r_sb_v[k-1] & ~(i_br_flush & (k < FD));
         assign w_rd_nxt[k] = r_sb_rd[k-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_sb_v  <= '0;
         r_sb_rd <= '{default: '0};
      end else if (!i_sram_stall) begin
         r_sb_v  <= w_v_nxt;
         r_sb_rd <= w_rd_nxt;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_bubble_cnt <= '0;
         r_flush_cnt  <= '0;
         r_stall_run  <= '0;
         r_timeout    <= 1'b0;
      end else begin
         if (!i_sram_stall && w_luh && !i_br_flush && r_bubble_cnt != CNT_MAX)
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
         if (!i_sram_stall && i_br_flush && r_flush_cnt != CNT_MAX)
            r_flush_cnt <= r_flush_cnt + 1'b1;
         r_stall_run <= !i_sram_stall ? '0 : (r_stall_run == RUN_MAX) ? r_stall_run : r_stall_run + 1'b1;
         if (i_sram_stall && r_stall_run == RUN_MAX)
            r_timeout <= 1'b1;
      end

   assign o_pc_wren      = ~i_sram_stall & (i_br_flush | ~w_luh);
   assign o_ifid_wren    = ~i_sram_stall & (i_br_flush | ~w_luh);
   assign o_idex_wren    = ~i_sram_stall;
   assign o_exmem_wren   = ~i_sram_stall;
   assign o_memwb_wren   = ~i_sram_stall;
   assign o_ifid_clear   = ~i_sram_stall & i_br_flush;
   assign o_idex_clear   = ~i_sram_stall & (i_br_flush | w_luh);
   assign o_exmem_clear  = ~i_sram_stall & i_br_flush;
   assign o_bubble_cnt   = r_bubble_cnt;
   assign o_flush_cnt    = r_flush_cnt;
   assign o_sram_timeout = r_timeout;
endmodule

// File: tb/tb_hdu_sb.sv
// tb_hdu_sb: drives a LOAD_LAT=3 unit and a LOAD_LAT=1 unit (2-bit counters,
// one-cycle watchdog) with the same directed vectors and checks both.
module tb_hdu_sb;
   localparam logic [7:0] N = 8'hF8, B = 8'h3A, F = 8'hFF, S = 8'h00;

   typedef struct {
      logic sr, fl;
      logic [4:0] rs1; logic u1;
      logic [4:0] rs2; logic u2;
      logic [4:0] rd; logic wr, ld;
      logic [7:0] e3, e1;
      int b3, b1, f;
   } vec_t;

   logic clk = 0, rst_n = 0;
   logic sr = 0, fl = 0, u1 = 0, u2 = 0, wr = 0, ld = 0;
   logic [4:0] rs1 = 0, rs2 = 0, rd = 0;
   logic [7:0] c3, c1;
   logic [15:0] b3, f3;
   logic [1:0] b1, f1;
   logic t3, t1;
   int total = 0, bad = 0;
   vec_t tbl[$];

   always #5 clk = ~clk;

   hdu_sb #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(16), .SRAM_TIMEOUT(8)) u3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_sram_stall(sr), .i_br_flush(fl),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
      .i_id_rd(rd), .i_id_rdwren(wr), .i_id_mem_rden(ld),
      .o_pc_wren(c3[7]), .o_ifid_wren(c3[6]), .o_idex_wren(c3[5]), .o_exmem_wren(c3[4]),
      .o_memwb_wren(c3[3]), .o_ifid_clear(c3[2]), .o_idex_clear(c3[1]), .o_exmem_clear(c3[0]),
      .o_bubble_cnt(b3), .o_flush_cnt(f3), .o_sram_timeout(t3));

   hdu_sb #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(2), .CNT_W(2), .SRAM_TIMEOUT(1)) u1d (
      .i_clk(clk), .i_rst_n(rst_n), .i_sram_stall(sr), .i_br_flush(fl),
      .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_rs1_used(u1), .i_id_rs2_used(u2),
      .i_id_rd(rd), .i_id_rdwren(wr), .i_id_mem_rden(ld),
      .o_pc_wren(c1[7]), .o_ifid_wren(c1[6]), .o_idex_wren(c1[5]), .o_exmem_wren(c1[4]),
      .o_memwb_wren(c1[3]), .o_ifid_clear(c1[2]), .o_idex_clear(c1[1]), .o_exmem_clear(c1[0]),
      .o_bubble_cnt(b1), .o_flush_cnt(f1), .o_sram_timeout(t1));

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic a_sr, a_fl, input logic [4:0] a_rs1, input logic a_u1,
                               input logic [4:0] a_rs2, input logic a_u2, input logic [4:0] a_rd,
                               input logic a_wr, a_ld, input logic [7:0] a_e3, a_e1,
                               input int a_b3, a_b1, a_f);
      vec_t v;
      v.sr = a_sr; v.fl = a_fl; v.rs1 = a_rs1; v.u1 = a_u1; v.rs2 = a_rs2; v.u2 = a_u2;
      v.rd = a_rd; v.wr = a_wr; v.ld = a_ld; v.e3 = a_e3; v.e1 = a_e1;
      v.b3 = a_b3; v.b1 = a_b1; v.f = a_f;
      return v;
   endfunction

   task automatic idle();
      sr = 0; fl = 0; rs1 = 0; u1 = 0; rs2 = 0; u2 = 0; rd = 0; wr = 0; ld = 0;
   endtask

   initial begin
      // lw x7 ; add x8,x7,x7 held in IF/ID
      tbl.push_back(mk(0,0, 2,1,0,0, 7,1,1, N,N, 0,0,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,B, 0,0,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 1,1,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 2,1,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, N,N, 3,1,0));
      // lw x7 ; independent ; add x8,x7,x7
      tbl.push_back(mk(0,0, 2,1,0,0, 7,1,1, N,N, 3,1,0));
      tbl.push_back(mk(0,0, 1,1,0,0, 3,1,0, N,N, 3,1,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 3,1,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 4,1,0));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, N,N, 5,1,0));
      // lw x0 / use x0 ; lw x9 / rs1=9 unused
      tbl.push_back(mk(0,0, 2,1,0,0, 0,1,1, N,N, 5,1,0));
      tbl.push_back(mk(0,0, 0,1,0,1, 6,1,0, N,N, 5,1,0));
      tbl.push_back(mk(0,0, 2,1,0,0, 9,1,1, N,N, 5,1,0));
      tbl.push_back(mk(0,0, 9,0,1,1, 6,1,0, N,N, 5,1,0));
      tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0, N,N, 5,1,0));
      tbl.push_back(mk(0,0, 0,0,0,0, 0,0,0, N,N, 5,1,0));
      // lw x4 ; flush with consumer in IF/ID ; consumer
      tbl.push_back(mk(0,0, 2,1,0,0, 4,1,1, N,N, 5,1,0));
      tbl.push_back(mk(0,1, 4,1,0,0, 6,1,0, F,F, 5,1,0));
      tbl.push_back(mk(0,0, 4,1,0,0, 6,1,0, N,N, 5,1,1));
      // lw x4 ; indep ; flush ; consumer -> sb[2] survives flush on LOAD_LAT=3
      tbl.push_back(mk(0,0, 2,1,0,0, 4,1,1, N,N, 5,1,1));
      tbl.push_back(mk(0,0, 1,1,0,0, 3,1,0, N,N, 5,1,1));
      tbl.push_back(mk(0,1, 0,0,0,0, 0,0,0, F,F, 5,1,1));
      tbl.push_back(mk(0,0, 4,1,0,0, 6,1,0, B,N, 5,1,2));
      tbl.push_back(mk(0,0, 4,1,0,0, 6,1,0, N,N, 6,1,2));
      // lw x7 ; add held under 3 stall cycles (one with flush) ; then released
      tbl.push_back(mk(0,0, 2,1,0,0, 7,1,1, N,N, 6,1,2));
      tbl.push_back(mk(1,0, 7,1,7,1, 8,1,0, S,S, 6,1,2));
      tbl.push_back(mk(1,1, 7,1,7,1, 8,1,0, S,S, 6,1,2));
      tbl.push_back(mk(1,0, 7,1,7,1, 8,1,0, S,S, 6,1,2));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,B, 6,1,2));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 7,2,2));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, B,N, 8,2,2));
      tbl.push_back(mk(0,0, 7,1,7,1, 8,1,0, N,N, 9,2,2));
      // rs2 path, then drive the 2-bit counter into saturation
      tbl.push_back(mk(0,0, 2,1,0,0, 5,1,1, N,N, 9,2,2));
      tbl.push_back(mk(0,0, 1,1,5,1, 8,1,0, B,B, 9,2,2));
      tbl.push_back(mk(0,0, 1,1,5,1, 8,1,0, B,N, 10,3,2));
      tbl.push_back(mk(0,0, 1,1,5,1, 8,1,0, B,N, 11,3,2));
      tbl.push_back(mk(0,0, 1,1,5,1, 8,1,0, N,N, 12,3,2));
      tbl.push_back(mk(0,0, 2,1,0,0, 5,1,1, N,N, 12,3,2));
      tbl.push_back(mk(0,0, 5,1,0,0, 8,1,0, B,B, 12,3,2));
      tbl.push_back(mk(0,0, 5,1,0,0, 8,1,0, B,N, 13,3,2));
      tbl.push_back(mk(0,0, 5,1,0,0, 8,1,0, B,N, 14,3,2));
      tbl.push_back(mk(0,0, 5,1,0,0, 8,1,0, N,N, 15,3,2));

      idle();
      repeat (2) @(negedge clk);
      chk("rst ctrl3", c3, N); chk("rst ctrl1", c1, N);
      chk("rst bub3", b3, 0); chk("rst flu3", f3, 0); chk("rst to3", t3, 0);
      chk("rst bub1", b1, 0); chk("rst flu1", f1, 0); chk("rst to1", t1, 0);
      rst_n = 1;

      foreach (tbl[i]) begin
         @(negedge clk);
         sr = tbl[i].sr; fl = tbl[i].fl; rs1 = tbl[i].rs1; u1 = tbl[i].u1;
         rs2 = tbl[i].rs2; u2 = tbl[i].u2; rd = tbl[i].rd; wr = tbl[i].wr; ld = tbl[i].ld;
         #1;
         chk($sformatf("v%0d ctrl3", i), c3, tbl[i].e3);
         chk($sformatf("v%0d ctrl1", i), c1, tbl[i].e1);
         chk($sformatf("v%0d bub3", i), b3, tbl[i].b3);
         chk($sformatf("v%0d bub1", i), b1, tbl[i].b1);
         chk($sformatf("v%0d flu3", i), f3, tbl[i].f);
         chk($sformatf("v%0d flu1", i), f1, tbl[i].f);
      end
      @(negedge clk); idle(); #1;
      chk("end bub3", b3, 15); chk("end bub1 sat", b1, 3);
      chk("end flu3", f3, 2); chk("end flu1", f1, 2);
      chk("end to3", t3, 0); chk("end to1", t1, 1);

      // 7 stall cycles: one short of the watchdog
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); sr = 1; #1;
         chk("stall7 ctrl3", c3, S);
      end
      @(negedge clk); sr = 0; #1;
      chk("stall7 to3", t3, 0);
      chk("stall7 bub3", b3, 15);

      // 8 stall cycles: trips on the 8th edge and stays set
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); sr = 1; #1;
         chk("stall8 pre to3", t3, 0);
      end
      @(negedge clk); sr = 0; #1;
      chk("stall8 to3", t3, 1);
      @(negedge clk); #1;
      chk("stall8 sticky to3", t3, 1);

      // pending load, then async reset mid-stall must empty the scoreboard
      @(negedge clk); rs1 = 2; u1 = 1; rd = 6; wr = 1; ld = 1;
      @(negedge clk); idle(); sr = 1;
      #2 rst_n = 0;
      #1;
      chk("arst to3", t3, 0); chk("arst to1", t1, 0);
      chk("arst bub3", b3, 0); chk("arst flu3", f3, 0); chk("arst bub1", b1, 0);
      @(negedge clk); rst_n = 1; sr = 0; rs1 = 6; u1 = 1; rd = 8; wr = 1;
      #1;
      chk("arst sb3 empty", c3, N); chk("arst sb1 empty", c1, N);
      @(negedge clk); idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
